// File: rtl/common.sv
// Shared bus types used by the instruction-fetch side of the core.
package common;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-register types and reset constants shared between pipeline stages.
package pipes;

    localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        valid;
    } fetch_data_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding bus request, one buffered instruction for decode,
// and redirect handling that lets an in-flight request finish before refetching.
module fetch_stage
    import common::*;
    import pipes::*;
#(
    parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        out_ready
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [63:0] r_pc, w_pc_nxt;
    logic        r_kill, w_kill_nxt;
    logic [63:0] r_kill_pc, w_kill_pc_nxt;
    fetch_data_t r_out, w_out_nxt;
    ibus_req_t   w_ireq;
    ibus_resp_t  w_iresp;
    logic        w_xfer;

    assign w_iresp = {iresp_data_ok, iresp_data};
    assign w_xfer  = r_out.valid && out_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_kill_nxt    = r_kill;
        w_kill_pc_nxt = r_kill_pc;
        w_out_nxt     = r_out;
        // Gated by reset so the bus sees no request while the block is held in reset.
        w_ireq.valid  = reset && (r_state != S_HOLD);
        w_ireq.addr   = r_pc;
        case (r_state)
            S_REQ: begin
                if (redirect_valid) w_pc_nxt = redirect_pc;
                else                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_iresp.data_ok) begin
                    if (r_kill || redirect_valid) begin
                        // Drop the returning word; the newest redirect target wins.
                        w_state_nxt = S_REQ;
                        w_pc_nxt    = redirect_valid ? redirect_pc : r_kill_pc;
                        w_kill_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_out_nxt   = '{instr: w_iresp.data, pc: r_pc, valid: 1'b1};
                    end
                end else if (redirect_valid) begin
                    w_kill_nxt    = 1'b1;
                    w_kill_pc_nxt = redirect_pc;
                end
            end
            S_HOLD: begin
                if (redirect_valid || w_xfer) begin
                    w_state_nxt     = S_REQ;
                    w_out_nxt.valid = 1'b0;
                    w_pc_nxt        = redirect_valid ? redirect_pc : r_pc + 64'd4;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_REQ;
            r_pc      <= PC_RESET;
            r_kill    <= 1'b0;
            r_kill_pc <= '0;
            r_out     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_kill    <= w_kill_nxt;
            r_kill_pc <= w_kill_pc_nxt;
            r_out     <= w_out_nxt;
        end
    end

    assign ireq_valid = w_ireq.valid;
    assign ireq_addr  = w_ireq.addr;
    assign out_valid  = r_out.valid;
    assign out_instr  = r_out.instr;
    assign out_pc     = r_out.pc;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_RESET, default 64'h0000_0000_8000_0000, is the first fetch address after reset.
REQ-002 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, is a synchronous active-low reset: reset==0 at a clk edge resets the block.
REQ-004 Port ireq_valid, output, 1, is the instruction-bus request strobe.
REQ-005 Port ireq_addr, output, 64, is the request address.
REQ-006 Port iresp_data_ok, input, 1, marks the single-cycle response for the outstanding request.
REQ-007 Port iresp_data, input, 32 (u32), is the instruction word, valid when iresp_data_ok==1.
REQ-008 Port redirect_valid, input, 1, is a one-cycle pulse from execute for a taken branch or jump.
REQ-009 Port redirect_pc, input, 64, is the redirect target, sampled when redirect_valid==1.
REQ-010 Port out_valid, output, 1, marks a fetched instruction presented to decode.
REQ-011 Port out_instr, output, 32 (u32), is the instruction word consumed by the decoder.
REQ-012 Port out_pc, output, 64, is the address of out_instr.
REQ-013 Port out_ready, input, 1, is decode acceptance; a transfer occurs when out_valid && out_ready.

Function
REQ-014 The FSM SHALL have three states: REQ (ireq_valid=1), WAIT (request outstanding, ireq_valid=1), HOLD (instruction buffered, ireq_valid=0).
REQ-015 REQ->WAIT next cycle; WAIT->HOLD on iresp_data_ok with no kill pending; WAIT->REQ on iresp_data_ok with kill pending; HOLD->REQ on transfer or redirect.
REQ-016 ireq_addr SHALL equal the fetch PC and stay stable from assertion of ireq_valid until iresp_data_ok.
REQ-017 On iresp_data_ok (not killed), out_instr/out_pc SHALL register iresp_data and the fetch PC, and out_valid SHALL rise the next cycle; minimum latency is 1 cycle from data_ok.
REQ-018 out_valid, out_instr and out_pc SHALL hold constant while out_valid && !out_ready.
REQ-019 On a transfer, fetch PC SHALL advance by 4 (64-bit wrap, no trap), out_valid SHALL drop, and the next request SHALL issue the following cycle.
REQ-020 Redirect in REQ or HOLD SHALL load fetch PC=redirect_pc, clear out_valid, and go to REQ the next cycle.
REQ-021 Redirect in WAIT SHALL latch redirect_pc, keep the outstanding request unchanged, set kill, and discard the returning response; then REQ issues at redirect_pc.
REQ-022 Redirect coincident with iresp_data_ok in WAIT SHALL discard that response and issue the target next.
REQ-023 Redirect coincident with a transfer SHALL take priority over the +4 increment; the transferred instruction is still consumed.
REQ-024 A later redirect SHALL overwrite an earlier latched target while kill is pending.
REQ-025 iresp_data_ok outside WAIT SHALL be ignored.

Reset
REQ-026 While reset==0, state=REQ, fetch PC=PC_RESET, kill=0, out_valid=0, out_instr=0, out_pc=0, and ireq_valid=0.
REQ-027 After reset deasserts, the first request (ireq_valid=1, addr=PC_RESET) SHALL issue in the first cycle.
REQ-028 Reset asserted mid-WAIT SHALL abandon the request; any data_ok arriving after reset release, before the first new request, SHALL be ignored.

Structure
REQ-029 Type fetch_data_t {instr u32; pc u64; valid} and PC_RESET's default SHALL live in pipes; the ibus request/response structs SHALL live in common.
REQ-030 The state enum SHALL be local to the module; no sub-module is required, and the output register is inline.

Verification
REQ-031 Reset release, bus responds 2 cycles after each request, out_ready=1: out_pc sequence 8000_0000, 8000_0004, 8000_0008.
REQ-032 out_ready=0 for 5 cycles with out_valid=1: outputs frozen, ireq_valid=0, no PC advance.
REQ-033 Redirect to 8000_0100 in WAIT for 8000_0004: response discarded, next out_pc=8000_0100, and 8000_0004 is never presented.
REQ-034 Redirect coincident with data_ok: that word is dropped, and the next request addr equals the target.
REQ-035 Redirect coincident with a transfer at 8000_0010, target 8000_0200: 8000_0010 is consumed, and the next request is 8000_0200, not 8000_0014.
REQ-036 reset=0 during WAIT, then a stale data_ok: out_valid stays 0, and the first request after release is at PC_RESET.
